// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and types used by the NTT, invNTT and pointwise blocks.
// Coefficients are 32-bit signed, packed little-end-first into flat vectors.
package dilithium_pkg;

    localparam int K       = 6;
    localparam int N       = 256;
    localparam int LANES   = 8;
    localparam int COEFF_W = 32;

    localparam logic signed [31:0] Q    = 32'sd8380417;
    localparam logic signed [31:0] QINV = 32'sd58728449;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/montgomery_reduce_32bit.sv
// Combinational Montgomery reduction: r = (a - t*Q) >>> 32 with t = low32(low32(a) * QINV).
// For |a| < Q*2^31 the result lies in (-Q, Q).
module montgomery_reduce_32bit
    import dilithium_pkg::*;
(
    input  logic signed [63:0] a,
    output logic signed [31:0] r
);

    logic        [31:0] t;
    logic signed [63:0] d;

    assign t = a[31:0] * QINV;
    // Low 32 bits of d are zero by construction of t, so the shift is exact.
    assign d = a - 64'($signed(t)) * 64'(Q);
    assign r = 32'(d >>> 32);

endmodule

// File: rtl/polyveck_pointwise_poly_montgomery.sv
// Pointwise Montgomery product of polynomial c with each polynomial of K-vector v.
// One chunk of LANES coefficients is issued per RUN cycle; products are registered, then reduced.
module polyveck_pointwise_poly_montgomery #(
    parameter int K     = dilithium_pkg::K,
    parameter int N     = dilithium_pkg::N,
    parameter int LANES = dilithium_pkg::LANES
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [N*32-1:0]                    c_in,
    input  logic [K*N*32-1:0]                  v_in,
    output logic [K*N*32-1:0]                  v_out,
    output logic                               done,
    output dilithium_pkg::state_t              state_dbg
);

    import dilithium_pkg::*;

    localparam int CHUNKS = N / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PW     = (K > 1) ? $clog2(K) : 1;

    state_t state, state_next;

    logic [PW-1:0] poly_idx;
    logic [CW-1:0] chunk_idx;
    logic          issue;
    logic          last_chunk;

    logic                p_valid;
    logic [PW-1:0]       p_poly;
    logic [CW-1:0]       p_chunk;
    logic signed [63:0]  prod_next [LANES];
    logic signed [63:0]  p_prod    [LANES];
    logic signed [31:0]  red       [LANES];

    assign last_chunk = (poly_idx == PW'(K - 1)) && (chunk_idx == CW'(CHUNKS - 1));
    assign state_dbg  = state;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                issue = 1'b1;
                if (last_chunk) state_next = FLUSH;
            end
            FLUSH:   state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poly_idx  <= '0;
            chunk_idx <= '0;
        end else if (issue) begin
            if (chunk_idx == CW'(CHUNKS - 1)) begin
                chunk_idx <= '0;
                poly_idx  <= last_chunk ? '0 : poly_idx + 1'b1;
            end else begin
                chunk_idx <= chunk_idx + 1'b1;
            end
        end else if (state == IDLE && start) begin
            poly_idx  <= '0;
            chunk_idx <= '0;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_next[l] =
                64'($signed(c_in[(int'(chunk_idx) * LANES + l) * 32 +: 32])) *
                64'($signed(v_in[(int'(poly_idx) * N + int'(chunk_idx) * LANES + l) * 32 +: 32]));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_valid <= 1'b0;
            p_poly  <= '0;
            p_chunk <= '0;
            for (int l = 0; l < LANES; l++) p_prod[l] <= '0;
        end else begin
            p_valid <= issue;
            if (issue) begin
                p_poly  <= poly_idx;
                p_chunk <= chunk_idx;
                for (int l = 0; l < LANES; l++) p_prod[l] <= prod_next[l];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_red
        montgomery_reduce_32bit u_red (
            .a (p_prod[l]),
            .r (red[l])
        );
    end

    // Entries outside the chunk being written keep their previous contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_out <= '0;
        end else if (p_valid) begin
            for (int l = 0; l < LANES; l++) begin
                v_out[(int'(p_poly) * N + int'(p_chunk) * LANES + l) * 32 +: 32] <= red[l];
            end
        end
    end

endmodule
